decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/riscv_pkg.sv | 63 ++++++
 rtl/imm_gen.sv | 23 ++
 rtl/decode_stage.sv | 119 +++++++++++
 tb/tb_decode_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: register width, base opcodes, immediate formats and opcode classifiers.
// Used by the decode stage and by the imm_gen sub-module.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_t;

    // Unknown opcodes map to FMT_R so they carry a zero immediate.
    function automatic imm_fmt_t opc_fmt(input logic [6:0] opc);
        imm_fmt_t f;
        case (opc)
            OPC_LUI, OPC_AUIPC:                               f = FMT_U;
            OPC_JAL:                                          f = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FENCE,
            OPC_SYSTEM:                                       f = FMT_I;
            OPC_STORE:                                        f = FMT_S;
            OPC_BRANCH:                                       f = FMT_B;
            default:                                          f = FMT_R;
        endcase
        return f;
    endfunction

    function automatic logic opc_legal(input logic [6:0] opc);
        logic l;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: l = 1'b1;
            default:                                             l = 1'b0;
        endcase
        return l;
    endfunction

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        logic w;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM,
            OPC_OP:  w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator, sign-extended from instr[31].
// Purely combinational: zero latency, no flow control.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: single-entry register with operand read, writeback bypass and load-use stall.
// Latency: one cycle from acceptance to out_valid. Backpressure: valid/ready; outputs hold while !out_ready.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int FWD_EN = 1
)(
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            in_ready,

    output logic [4:0]      rf_addr1,
    output logic [4:0]      rf_addr2,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,

    input  logic            wb_write,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,

    input  logic            ex_load,
    input  logic [4:0]      ex_rd,
    input  logic            flush,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_rd_we,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    imm_fmt_t        fmt;
    logic            legal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            stall;
    logic            slot_free;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign rf_addr1 = in_instr[19:15];
    assign rf_addr2 = in_instr[24:20];
    assign fmt      = opc_fmt(opcode);
    assign legal    = opc_legal(opcode);

    // Illegal words never read operands, so they can never stall the pipe.
    assign uses_rs1 = legal & (fmt == FMT_I || fmt == FMT_S || fmt == FMT_B || fmt == FMT_R);
    assign uses_rs2 = legal & (fmt == FMT_S || fmt == FMT_B || fmt == FMT_R);

    assign stall = in_valid & ex_load & (ex_rd != 5'd0) &
                   ((uses_rs1 & (ex_rd == rf_addr1)) | (uses_rs2 & (ex_rd == rf_addr2)));

    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = slot_free & ~stall & ~flush;

    imm_gen u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt),
        .imm   (imm)
    );

    always_comb begin
        op1 = rf_rs1;
        op2 = rf_rs2;
        if (FWD_EN != 0 && wb_write && wb_addr != 5'd0 && wb_addr == rf_addr1) op1 = wb_data;
        if (FWD_EN != 0 && wb_write && wb_addr != 5'd0 && wb_addr == rf_addr2) op2 = wb_data;
        if (rf_addr1 == 5'd0) op1 = '0;
        if (rf_addr2 == 5'd0) op2 = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_val  <= '0;
            out_rs2_val  <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_rd_we    <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (slot_free) begin
            out_valid <= in_valid & in_ready;
            if (in_valid & in_ready) begin
                out_pc       <= in_pc;
                out_rs1_val  <= op1;
                out_rs2_val  <= op2;
                out_imm      <= imm;
                out_rd       <= rd;
                out_opcode   <= opcode;
                out_funct3   <= in_instr[14:12];
                out_funct7b5 <= in_instr[30];
                out_rd_we    <= legal & opc_writes_rd(opcode) & (rd != 5'd0);
                out_illegal  <= ~legal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, bypass, load-use stall,
// backpressure, flush and asynchronous reset, with hand-computed expected values.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic [4:0]  rf_addr1;
    logic [4:0]  rf_addr2;
    logic [31:0] rf_rs1;
    logic [31:0] rf_rs2;
    logic        wb_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_rd_we;
    logic        out_illegal;

    logic [31:0] regs [32];
    int          vectors;
    int          miscompares;

    assign rf_rs1 = regs[rf_addr1];
    assign rf_rs2 = regs[rf_addr2];

    decode_stage #(.FWD_EN(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .in_ready     (in_ready),
        .rf_addr1     (rf_addr1),
        .rf_addr2     (rf_addr2),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .wb_write     (wb_write),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .ex_load      (ex_load),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_rd_we    (out_rd_we),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = vld;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[0] = 32'hDEAD_0000;
        regs[1] = 32'h0000_0000;
        regs[2] = 32'hBBBB_0002;
        regs[7] = 32'h0000_0077;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        wb_write  = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;
        ex_load   = 1'b0;
        ex_rd     = 5'd0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #2;
        chk("rst_valid",   32'(out_valid),   32'h0);
        chk("rst_rd_we",   32'(out_rd_we),   32'h0);
        chk("rst_illegal", 32'(out_illegal), 32'h0);
        chk("rst_imm",     out_imm,          32'h0);
        chk("rst_pc",      out_pc,           32'h0);
        chk("rst_rs1",     out_rs1_val,      32'h0);

        // addi x5,x0,-1 on the first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'hFFF0_0293, 32'h0000_0100);
        #1;
        chk("addi_in_ready", 32'(in_ready), 32'h1);
        chk("addi_rf_addr2", 32'(rf_addr2), 32'd31);
        tick();
        chk("addi_valid",  32'(out_valid),  32'h1);
        chk("addi_imm",    out_imm,         32'hFFFF_FFFF);
        chk("addi_rd",     32'(out_rd),     32'd5);
        chk("addi_rd_we",  32'(out_rd_we),  32'h1);
        chk("addi_rs1",    out_rs1_val,     32'h0);
        chk("addi_pc",     out_pc,          32'h0000_0100);
        chk("addi_opcode", 32'(out_opcode), 32'h13);

        // add x3,x1,x2 with writeback of x1 in the same cycle
        drive(1'b1, 32'h0020_81B3, 32'h0000_0104);
        wb_write = 1'b1;
        wb_addr  = 5'd1;
        wb_data  = 32'h0000_1234;
        tick();
        wb_write = 1'b0;
        chk("add_rs1_fwd", out_rs1_val,      32'h0000_1234);
        chk("add_rs2",     out_rs2_val,      32'hBBBB_0002);
        chk("add_rd",      32'(out_rd),      32'd3);
        chk("add_imm",     out_imm,          32'h0);
        chk("add_f7b5",    32'(out_funct7b5), 32'h0);

        // sub x1,x7,x2 against a load to x7: one stall cycle, one bubble
        drive(1'b1, 32'h4023_80B3, 32'h0000_0108);
        ex_load = 1'b1;
        ex_rd   = 5'd7;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("stall_bubble", 32'(out_valid), 32'h0);
        ex_load = 1'b0;
        #1;
        chk("unstall_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("sub_valid", 32'(out_valid),    32'h1);
        chk("sub_rs1",   out_rs1_val,       32'h0000_0077);
        chk("sub_f7b5",  32'(out_funct7b5), 32'h1);
        chk("sub_rd",    32'(out_rd),       32'd1);

        // lui x10 does not read rs1, so a load to its rs1 field (x8) must not stall
        drive(1'b1, 32'h1234_5537, 32'h0000_010C);
        ex_load = 1'b1;
        ex_rd   = 5'd8;
        #1;
        chk("lui_no_stall", 32'(in_ready), 32'h1);
        tick();
        ex_load = 1'b0;
        chk("lui_imm",   out_imm,         32'h1234_5000);
        chk("lui_rd",    32'(out_rd),     32'd10);
        chk("lui_rd_we", 32'(out_rd_we),  32'h1);

        // beq x1,x2,+8 held for three cycles under backpressure
        drive(1'b1, 32'h0020_8463, 32'h0000_0200);
        tick();
        chk("beq_imm",   out_imm,         32'h0000_0008);
        chk("beq_rd_we", 32'(out_rd_we),  32'h0);
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_00EF, 32'h0000_0204);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("hold_valid", 32'(out_valid), 32'h1);
            chk("hold_imm",   out_imm,        32'h0000_0008);
            chk("hold_pc",    out_pc,         32'h0000_0200);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);
        tick();
        chk("jal_imm",   out_imm,        32'h0000_0800);
        chk("jal_rd_we", 32'(out_rd_we), 32'h1);
        chk("jal_pc",    out_pc,         32'h0000_0204);

        // sw x2,-4(x1) back-to-back
        drive(1'b1, 32'hFE20_AE23, 32'h0000_0208);
        tick();
        chk("sw_valid", 32'(out_valid),  32'h1);
        chk("sw_imm",   out_imm,         32'hFFFF_FFFC);
        chk("sw_rd_we", 32'(out_rd_we),  32'h0);
        chk("sw_rs2",   out_rs2_val,     32'hBBBB_0002);

        // beq x0,x0,-4: negative B immediate, both operands from x0
        drive(1'b1, 32'hFE00_0EE3, 32'h0000_020C);
        tick();
        chk("bneg_imm", out_imm,     32'hFFFF_FFFC);
        chk("bneg_rs2", out_rs2_val, 32'h0);

        // illegal opcode 7'h7F with rd=1
        drive(1'b1, 32'h0000_00FF, 32'h0000_0210);
        tick();
        chk("ill_valid",   32'(out_valid),   32'h1);
        chk("ill_illegal", 32'(out_illegal), 32'h1);
        chk("ill_rd_we",   32'(out_rd_we),   32'h0);

        // addi x0,x1,5: rd=0 suppresses the write
        drive(1'b1, 32'h0050_8013, 32'h0000_0214);
        tick();
        chk("rd0_rd_we",   32'(out_rd_we),   32'h0);
        chk("rd0_imm",     out_imm,          32'h0000_0005);
        chk("rd0_illegal", 32'(out_illegal), 32'h0);

        // flush with an entry held, incoming word and out_ready all high
        drive(1'b1, 32'h0020_81B3, 32'h0000_0218);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("flush_valid", 32'(out_valid), 32'h0);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("flush_dropped", 32'(out_valid), 32'h0);

        // asynchronous reset mid-stream
        drive(1'b1, 32'hFFF0_0293, 32'h0000_0300);
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_imm",   out_imm,        32'h0);
        chk("async_rst_rd_we", 32'(out_rd_we), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
